// File: rtl/if_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, BTB update port, instruction
// memory handshake and the IF/ID latch outputs.
interface if_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        btb_update;
    logic [31:0] btb_update_pc;
    logic [31:0] btb_update_tgt;
    logic        btb_update_taken;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        ld_ifid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] ir;
    logic        br_predict;
    logic [31:0] tgtaddr;

    modport master (
        input  stall, redirect, redirect_pc,
        input  btb_update, btb_update_pc, btb_update_tgt, btb_update_taken,
        input  imem_resp, imem_rdata,
        output imem_read, imem_address,
        output ld_ifid, pc, pc_plus4, ir, br_predict, tgtaddr
    );

    modport slave (
        output stall, redirect, redirect_pc,
        output btb_update, btb_update_pc, btb_update_tgt, btb_update_taken,
        output imem_resp, imem_rdata,
        input  imem_read, imem_address,
        input  ld_ifid, pc, pc_plus4, ir, br_predict, tgtaddr
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: fetch PC, FETCH/HOLD/DROP request FSM, hold buffer
// for stalled fetches and a direct-mapped BTB with 2-bit counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060,
    parameter int          BTB_IDX  = 4
) (
    input  logic       clk,
    input  logic       reset,
    if_stage_if.master bus
);
    localparam int ENTRIES = 1 << BTB_IDX;
    localparam int TAG_W   = 30 - BTB_IDX;

    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] hold_ir_q, hold_ir_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_tgt_q, hold_tgt_d;
    logic        hold_bp_q, hold_bp_d;

    logic             btb_vld_q [ENTRIES];
    logic [1:0]       btb_ctr_q [ENTRIES];
    logic [TAG_W-1:0] btb_tag_q [ENTRIES];
    logic [31:0]      btb_tgt_q [ENTRIES];

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    logic [BTB_IDX-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]   lk_tag, up_tag;
    logic               lk_pred, up_hit;
    logic [31:0]        lk_tgt, pc_inc, pc_next;
    logic               unused_bits;

    assign lk_idx  = pc_q[BTB_IDX+1:2];
    assign lk_tag  = pc_q[31:BTB_IDX+2];
    assign lk_pred = btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag) && btb_ctr_q[lk_idx][1];
    assign lk_tgt  = lk_pred ? btb_tgt_q[lk_idx] : 32'd0;
    assign pc_inc  = pc_q + 32'd4;
    assign pc_next = lk_pred ? btb_tgt_q[lk_idx] : pc_inc;

    assign up_idx      = bus.btb_update_pc[BTB_IDX+1:2];
    assign up_tag      = bus.btb_update_pc[31:BTB_IDX+2];
    assign up_hit      = btb_vld_q[up_idx] && (btb_tag_q[up_idx] == up_tag);
    assign unused_bits = ^bus.btb_update_pc[1:0];

    // Lookup reads the registered arrays, so a same-cycle update is seen next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_vld_q[i] <= 1'b0;
                btb_ctr_q[i] <= 2'b01;
            end
        end else if (bus.btb_update) begin
            if (up_hit) begin
                btb_ctr_q[up_idx] <= bus.btb_update_taken ? ctr_inc(btb_ctr_q[up_idx])
                                                          : ctr_dec(btb_ctr_q[up_idx]);
            end else if (bus.btb_update_taken) begin
                btb_vld_q[up_idx] <= 1'b1;
                btb_ctr_q[up_idx] <= 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.btb_update && bus.btb_update_taken) begin
            btb_tag_q[up_idx] <= up_tag;
            btb_tgt_q[up_idx] <= bus.btb_update_tgt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            drop_addr_q <= 32'd0;
            hold_ir_q   <= 32'd0;
            hold_pc_q   <= 32'd0;
            hold_tgt_q  <= 32'd0;
            hold_bp_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            hold_ir_q   <= hold_ir_d;
            hold_pc_q   <= hold_pc_d;
            hold_tgt_q  <= hold_tgt_d;
            hold_bp_q   <= hold_bp_d;
        end
    end

    logic        read_c, ld_c, bp_c;
    logic [31:0] addr_c, pc_c, pc4_c, ir_c, tgt_c;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        hold_ir_d   = hold_ir_q;
        hold_pc_d   = hold_pc_q;
        hold_tgt_d  = hold_tgt_q;
        hold_bp_d   = hold_bp_q;
        read_c      = 1'b0;
        addr_c      = pc_q;
        ld_c        = 1'b0;
        pc_c        = 32'd0;
        pc4_c       = 32'd0;
        ir_c        = 32'd0;
        bp_c        = 1'b0;
        tgt_c       = 32'd0;
        unique case (state_q)
            FETCH: begin
                read_c = 1'b1;
                addr_c = pc_q;
                pc_c   = pc_q;
                pc4_c  = pc_inc;
                ir_c   = bus.imem_rdata;
                bp_c   = lk_pred;
                tgt_c  = lk_tgt;
                if (bus.redirect) begin
                    pc_d = bus.redirect_pc;
                    // The in-flight request keeps its address until memory answers.
                    if (!bus.imem_resp) begin
                        drop_addr_d = pc_q;
                        state_d     = DROP;
                    end
                end else if (bus.imem_resp) begin
                    pc_d = pc_next;
                    if (bus.stall) begin
                        hold_ir_d  = bus.imem_rdata;
                        hold_pc_d  = pc_q;
                        hold_bp_d  = lk_pred;
                        hold_tgt_d = lk_tgt;
                        state_d    = HOLD;
                    end else begin
                        ld_c = 1'b1;
                    end
                end
            end
            HOLD: begin
                pc_c  = hold_pc_q;
                pc4_c = hold_pc_q + 32'd4;
                ir_c  = hold_ir_q;
                bp_c  = hold_bp_q;
                tgt_c = hold_tgt_q;
                if (bus.redirect) begin
                    pc_d    = bus.redirect_pc;
                    state_d = FETCH;
                end else if (!bus.stall) begin
                    ld_c    = 1'b1;
                    state_d = FETCH;
                end
            end
            DROP: begin
                read_c = 1'b1;
                addr_c = drop_addr_q;
                if (bus.redirect) pc_d = bus.redirect_pc;
                if (bus.imem_resp) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Outputs are forced quiet for as long as reset is held.
    assign bus.imem_read    = reset & read_c;
    assign bus.imem_address = reset ? addr_c : 32'd0;
    assign bus.ld_ifid      = reset & ld_c;
    assign bus.pc           = reset ? pc_c : 32'd0;
    assign bus.pc_plus4     = reset ? pc4_c : 32'd0;
    assign bus.ir           = reset ? ir_c : 32'd0;
    assign bus.br_predict   = reset & bp_c;
    assign bus.tgtaddr      = reset ? tgt_c : 32'd0;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random traffic, all
// checked against a transaction-level fetch/BTB model.
module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0060;
    localparam int          BTB_IDX  = 4;
    localparam int          N        = 1 << BTB_IDX;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_stage_if bus ();
    if_stage #(.RESET_PC(RESET_PC), .BTB_IDX(BTB_IDX)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          v;
        logic [31:0] bpc;
        logic [31:0] tgt;
        int          cnt;
    } btb_ent_t;

    btb_ent_t    m_btb [N];
    logic [31:0] m_pc, m_stale;
    bit          m_held, m_discard;
    logic [31:0] h_pc, h_ir, h_tgt;
    bit          h_bp;
    logic [31:0] seen_pc [$];

    logic        last_read, last_ld, last_bp;
    logic [31:0] last_addr, last_pc, last_tgt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % N);
    endfunction

    function automatic bit same_tag(input logic [31:0] a, input logic [31:0] b);
        return (a >> (BTB_IDX + 2)) == (b >> (BTB_IDX + 2));
    endfunction

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_stale   = 32'd0;
        m_held    = 1'b0;
        m_discard = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_btb[i].v   = 1'b0;
            m_btb[i].bpc = 32'd0;
            m_btb[i].tgt = 32'd0;
            m_btb[i].cnt = 1;
        end
    endtask

    // One clock cycle: apply inputs, check outputs against the model, advance model.
    task automatic cycu(input bit st, input bit rd, input logic [31:0] rdpc, input bit rsp,
                        input bit bu, input logic [31:0] bupc, input logic [31:0] butgt,
                        input bit butk);
        bit          read_e, ld_e, pred, ebp;
        logic [31:0] addr_e, pnext, epc, eir, etgt;
        int          li, ui;
        read_e = !m_held;
        addr_e = m_discard ? m_stale : m_pc;
        li     = idx_of(m_pc);
        pred   = m_btb[li].v && same_tag(m_btb[li].bpc, m_pc) && (m_btb[li].cnt >= 2);
        pnext  = pred ? m_btb[li].tgt : m_pc + 32'd4;

        bus.stall            = st;
        bus.redirect         = rd;
        bus.redirect_pc      = rdpc;
        bus.imem_resp        = rsp;
        bus.imem_rdata       = rsp ? mem_word(addr_e) : 32'hDEAD_BEEF;
        bus.btb_update       = bu;
        bus.btb_update_pc    = bupc;
        bus.btb_update_tgt   = butgt;
        bus.btb_update_taken = butk;
        #1;

        if (rd || m_discard) ld_e = 1'b0;
        else if (m_held)     ld_e = !st;
        else                 ld_e = rsp && !st;

        last_read = bus.imem_read;
        last_addr = bus.imem_address;
        last_ld   = bus.ld_ifid;
        last_pc   = bus.pc;
        last_bp   = bus.br_predict;
        last_tgt  = bus.tgtaddr;

        chk1("imem_read", bus.imem_read, read_e);
        if (read_e) chk("imem_address", bus.imem_address, addr_e);
        chk1("ld_ifid", bus.ld_ifid, ld_e);
        if (ld_e) begin
            if (m_held) begin
                epc = h_pc; eir = h_ir; ebp = h_bp; etgt = h_tgt;
            end else begin
                epc = m_pc; eir = mem_word(m_pc); ebp = pred;
                etgt = pred ? m_btb[li].tgt : 32'd0;
            end
            chk("pc", bus.pc, epc);
            chk("pc_plus4", bus.pc_plus4, epc + 32'd4);
            chk("ir", bus.ir, eir);
            chk1("br_predict", bus.br_predict, ebp);
            chk("tgtaddr", bus.tgtaddr, etgt);
        end
        if (bus.ld_ifid === 1'b1) seen_pc.push_back(bus.pc);

        if (m_held) begin
            if (rd) begin
                m_held = 1'b0;
                m_pc   = rdpc;
            end else if (!st) begin
                m_held = 1'b0;
            end
        end else if (m_discard) begin
            if (rd) m_pc = rdpc;
            if (rsp) m_discard = 1'b0;
        end else if (rd) begin
            if (!rsp) begin
                m_discard = 1'b1;
                m_stale   = m_pc;
            end
            m_pc = rdpc;
        end else if (rsp) begin
            if (st) begin
                m_held = 1'b1;
                h_pc   = m_pc;
                h_ir   = mem_word(m_pc);
                h_bp   = pred;
                h_tgt  = pred ? m_btb[li].tgt : 32'd0;
            end
            m_pc = pnext;
        end

        if (bu) begin
            ui = idx_of(bupc);
            if (m_btb[ui].v && same_tag(m_btb[ui].bpc, bupc)) begin
                if (butk) begin
                    m_btb[ui].cnt = (m_btb[ui].cnt < 3) ? m_btb[ui].cnt + 1 : 3;
                    m_btb[ui].tgt = butgt;
                end else begin
                    m_btb[ui].cnt = (m_btb[ui].cnt > 0) ? m_btb[ui].cnt - 1 : 0;
                end
            end else if (butk) begin
                m_btb[ui].v   = 1'b1;
                m_btb[ui].bpc = bupc;
                m_btb[ui].tgt = butgt;
                m_btb[ui].cnt = 2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit st, input bit rd, input logic [31:0] rdpc, input bit rsp);
        cycu(st, rd, rdpc, rsp, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    // Reset asserted between edges with busy inputs; BTB update must not land.
    task automatic do_reset();
        reset                = 1'b0;
        bus.stall            = 1'b0;
        bus.redirect         = 1'b0;
        bus.redirect_pc      = 32'h0000_0100;
        bus.imem_resp        = 1'b1;
        bus.imem_rdata       = 32'hFFFF_FFFF;
        bus.btb_update       = 1'b1;
        bus.btb_update_pc    = 32'h0000_0060;
        bus.btb_update_tgt   = 32'h0000_0040;
        bus.btb_update_taken = 1'b1;
        #1;
        chk1("rst_imem_read", bus.imem_read, 1'b0);
        chk1("rst_ld_ifid", bus.ld_ifid, 1'b0);
        chk("rst_ir", bus.ir, 32'd0);
        chk("rst_pc", bus.pc, 32'd0);
        chk("rst_pc_plus4", bus.pc_plus4, 32'd0);
        chk1("rst_br_predict", bus.br_predict, 1'b0);
        chk("rst_tgtaddr", bus.tgtaddr, 32'd0);
        @(posedge clk);
        #1;
        chk1("rst_imem_read_edge", bus.imem_read, 1'b0);
        chk1("rst_ld_ifid_edge", bus.ld_ifid, 1'b0);
        bus.btb_update = 1'b0;
        reset          = 1'b1;
        model_reset();
    endtask

    initial begin
        bit          st, rd, rsp, bu, butk;
        logic [31:0] rdpc, bupc, butgt;

        do_reset();

        // Steady fetch with a response every second cycle.
        seen_pc.delete();
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            cyc(0, 0, 0, 1);
        end
        chk("seq_count", 32'(seen_pc.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("seq_pc", (i < seen_pc.size()) ? seen_pc[i] : 32'hFFFF_FFFF, RESET_PC + 32'(4 * i));

        // Reset with a request pending, then stall across the 0x64 response.
        do_reset();
        cyc(0, 0, 0, 0);
        chk1("post_rst_read", last_read, 1'b1);
        chk("post_rst_addr", last_addr, RESET_PC);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 1);
        chk1("stall_resp_ld", last_ld, 1'b0);
        cyc(1, 0, 0, 0);
        chk1("hold_read", last_read, 1'b0);
        chk1("hold_ld", last_ld, 1'b0);
        cyc(1, 0, 0, 0);
        chk1("hold_read2", last_read, 1'b0);
        cyc(0, 0, 0, 0);
        chk1("hold_release_ld", last_ld, 1'b1);
        chk("hold_release_pc", last_pc, 32'h0000_0064);
        cyc(0, 0, 0, 0);
        chk("after_hold_addr", last_addr, 32'h0000_0068);

        // Redirect while 0x70 is outstanding.
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 32'h0000_0200, 0);
        chk1("redir_ld", last_ld, 1'b0);
        cyc(0, 0, 0, 0);
        chk("drop_addr", last_addr, 32'h0000_0070);
        chk1("drop_read", last_read, 1'b1);
        cyc(0, 0, 0, 1);
        chk1("drop_resp_ld", last_ld, 1'b0);
        cyc(0, 0, 0, 0);
        chk("redir_addr", last_addr, 32'h0000_0200);
        cyc(0, 0, 0, 1);
        chk1("redir_first_ld", last_ld, 1'b1);
        chk("redir_first_pc", last_pc, 32'h0000_0200);

        // Redirect together with response and stall.
        cyc(1, 1, 32'h0000_0300, 1);
        chk1("redir_stall_ld", last_ld, 1'b0);
        cyc(0, 0, 0, 0);
        chk1("redir_stall_read", last_read, 1'b1);
        chk("redir_stall_addr", last_addr, 32'h0000_0300);

        // BTB allocate, predict, then train to not-taken.
        cycu(0, 1, 32'h0000_0080, 1, 1, 32'h0000_0080, 32'h0000_0040, 1);
        cyc(0, 0, 0, 1);
        chk1("btb_pred", last_bp, 1'b1);
        chk("btb_tgt", last_tgt, 32'h0000_0040);
        cyc(0, 0, 0, 0);
        chk("btb_next_addr", last_addr, 32'h0000_0040);
        cycu(0, 0, 0, 0, 1, 32'h0000_0080, 32'h0000_0040, 0);
        cycu(0, 0, 0, 0, 1, 32'h0000_0080, 32'h0000_0040, 0);
        cyc(0, 1, 32'h0000_0080, 1);
        cyc(0, 0, 0, 1);
        chk1("btb_nt_pred", last_bp, 1'b0);
        chk("btb_nt_tgt", last_tgt, 32'd0);
        cyc(0, 0, 0, 0);
        chk("btb_nt_addr", last_addr, 32'h0000_0084);

        // Saturation: four taken, one not-taken still predicts taken.
        for (int i = 0; i < 4; i++)
            cycu(0, 0, 0, 0, 1, 32'h0000_0080, 32'h0000_0040, 1);
        cycu(0, 0, 0, 0, 1, 32'h0000_0080, 32'h0000_0040, 0);
        cyc(0, 1, 32'h0000_0080, 1);
        cyc(0, 0, 0, 1);
        chk1("sat_pred", last_bp, 1'b1);
        cyc(0, 0, 0, 0);

        // Reset mid-fetch clears the BTB.
        do_reset();
        cyc(0, 0, 0, 0);
        chk("refetch_addr", last_addr, RESET_PC);
        cyc(0, 1, 32'h0000_0080, 1);
        cyc(0, 0, 0, 1);
        chk1("cleared_ld", last_ld, 1'b1);
        chk1("cleared_pred", last_bp, 1'b0);

        // Random traffic in a small PC window so BTB hits and aliasing occur.
        for (int n = 0; n < 3000; n++) begin
            if (($urandom % 600) == 0) do_reset();
            st    = ($urandom % 100) < 30;
            rd    = ($urandom % 100) < 8;
            rdpc  = 32'($urandom_range(0, 127)) << 2;
            rsp   = !m_held && (($urandom % 2) == 0);
            bu    = ($urandom % 100) < 30;
            bupc  = 32'($urandom_range(0, 127)) << 2;
            butgt = 32'($urandom_range(0, 127)) << 2;
            butk  = ($urandom % 3) != 0;
            cycu(st, rd, rdpc, rsp, bu, bupc, butgt, butk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: IF_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000060, the first fetch address after reset.
REQ-002 SHALL have parameter BTB_IDX, default 4, giving 2^BTB_IDX direct-mapped BTB entries.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-005 stall  input  1  hazard unit holds the IF/ID latch.
REQ-006 redirect  input  1  EX-stage misprediction or jump correction.
REQ-007 redirect_pc  input  32  corrected fetch address.
REQ-008 btb_update  input  1  EX resolved a branch this cycle.
REQ-009 btb_update_pc  input  32  PC of the resolved branch.
REQ-010 btb_update_tgt  input  32  resolved target.
REQ-011 btb_update_taken  input  1  resolved direction.
REQ-012 imem_read  output  1  instruction-memory request.
REQ-013 imem_address  output  32  request address.
REQ-014 imem_resp  input  1  one-cycle response strobe.
REQ-015 imem_rdata  input  32  instruction word, valid with imem_resp.
REQ-016 ld_ifid  output  1  load strobe for the ID-stage latch.
REQ-017 pc, pc_plus4, ir  output  32 each  fetched PC, PC+4 and instruction, valid when ld_ifid=1.
REQ-018 br_predict  output  1  BTB predicted taken for this instruction.
REQ-019 tgtaddr  output  32  predicted target; 0 when br_predict=0.

Function
REQ-020 SHALL hold fetch PC register pc_q and FSM with states FETCH, HOLD, DROP.
REQ-021 FETCH: imem_read=1, imem_address=pc_q; request held stable until imem_resp.
REQ-022 FETCH, imem_resp=1, redirect=0, stall=0: ld_ifid=1, ir=imem_rdata, pc=pc_q, pc_plus4=pc_q+4 (mod 2^32); pc_q <= predicted next PC; stay FETCH.
REQ-023 FETCH, imem_resp=1, redirect=0, stall=1: capture ir, pc, prediction into hold buffer; ld_ifid=0; pc_q <= predicted next PC; go HOLD.
REQ-024 HOLD: imem_read=0; outputs driven from hold buffer; ld_ifid=!stall; when stall=0 go FETCH next cycle.
REQ-025 Redirect has priority over stall and response in every state.
REQ-026 redirect in FETCH with imem_resp=1, or in HOLD: discard the instruction, ld_ifid=0, pc_q <= redirect_pc, go FETCH.
REQ-027 redirect in FETCH with imem_resp=0: pc_q <= redirect_pc, go DROP; imem_read stays 1 with the old address (latched) until imem_resp.
REQ-028 DROP: discard response, ld_ifid=0; on imem_resp go FETCH; a further redirect in DROP overwrites pc_q.
REQ-029 BTB entry: valid, tag pc[31:BTB_IDX+2], target[31:0], 2-bit counter; index pc[BTB_IDX+1:2].
REQ-030 Lookup on pc_q combinational: hit = valid and tag match; br_predict = hit and counter[1]; predicted next PC = target if br_predict else pc_q+4.
REQ-031 Update on btb_update, hit at btb_update_pc: counter saturating +1 if taken, -1 if not (limits 0, 3); target rewritten when taken.
REQ-032 Update miss and taken: allocate/overwrite entry, valid=1, tag and target written, counter=2'b10; miss and not taken: no change.
REQ-033 Lookup and update to the same index in one cycle: lookup uses pre-update contents.
REQ-034 ld_ifid SHALL never be 1 in DROP or in the cycle redirect=1.

Reset
REQ-035 reset=0 asynchronously: pc_q=RESET_PC, state FETCH, all BTB valid=0 and counters=2'b01, hold buffer cleared.
REQ-036 During reset: imem_read=0, ld_ifid=0, ir=0, pc=0, pc_plus4=0, br_predict=0, tgtaddr=0.
REQ-037 First cycle after release: imem_read=1, imem_address=RESET_PC; a reset mid-request abandons it without waiting for imem_resp.

Verification
REQ-038 Release reset, imem_resp every 2nd cycle, rdata=32'h00000013 -> ld_ifid pulses with pc 0x60, 0x64, 0x68, pc_plus4 = pc+4, br_predict=0.
REQ-039 stall=1 for 3 cycles across a response at pc 0x64 -> HOLD, imem_read=0, ld_ifid=0 until stall drops, then one ld_ifid with pc 0x64, next request 0x68.
REQ-040 redirect to 0x200 while request for 0x70 pending -> DROP, 0x70 response discarded, next imem_address=0x200, next ld_ifid pc=0x200.
REQ-041 redirect coincident with imem_resp and stall=1 -> ld_ifid=0, no HOLD, next request at redirect_pc.
REQ-042 btb_update pc=0x80 tgt=0x40 taken=1, then fetch 0x80 -> br_predict=1, tgtaddr=0x40, next request 0x40; two not-taken updates -> br_predict=0, next 0x84.
REQ-043 Counter saturation: four taken updates then one not-taken at 0x80 -> still predicts taken (counter 2); reset mid-FETCH -> all outputs 0, BTB cleared, refetch at 0x60.
